// File: rtl/ysyx_22050710_arb_pkg.sv
// rtl/ysyx_22050710_arb_pkg.sv - shared state and owner encodings for the memory arbiter
package ysyx_22050710_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/ysyx_22050710_arb_pick.sv
// rtl/ysyx_22050710_arb_pick.sv - combinational IFU/LSU winner select
// YSYX_22050710_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_22050710_arb_pick
    import ysyx_22050710_arb_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_req,
`ifdef YSYX_22050710_ARB_RR_EN
    input  arb_owner_t last_gnt,
`endif
    output logic       ifu_win,
    output logic       lsu_win
);

`ifdef YSYX_22050710_ARB_RR_EN
    // On a tie the requester that was not granted last goes first.
    logic tie_to_ifu;
    assign tie_to_ifu = (last_gnt == OWN_LSU);
    assign ifu_win    = ifu_req & (~lsu_req | tie_to_ifu);
    assign lsu_win    = lsu_req & (~ifu_req | ~tie_to_ifu);
`else
    assign lsu_win = lsu_req;
    assign ifu_win = ifu_req & ~lsu_req;
`endif

endmodule

// File: rtl/ysyx_22050710_mem_arbiter.sv
// rtl/ysyx_22050710_mem_arbiter.sv - shares the single memory port between IFU and LSU
// Optional round-robin arbitration under YSYX_22050710_ARB_RR_EN.
module ysyx_22050710_mem_arbiter
    import ysyx_22050710_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ifu_req,
    input  logic [ADDR_WIDTH-1:0] i_ifu_addr,
    output logic                  o_ifu_gnt,
    output logic                  o_ifu_rvalid,
    output logic [DATA_WIDTH-1:0] o_ifu_rdata,
    input  logic                  i_lsu_req,
    input  logic                  i_lsu_wen,
    input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
    input  logic [DATA_WIDTH-1:0] i_lsu_wdata,
    input  logic [MASK_WIDTH-1:0] i_lsu_wmask,
    output logic                  o_lsu_gnt,
    output logic                  o_lsu_rvalid,
    output logic [DATA_WIDTH-1:0] o_lsu_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_wen,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [MASK_WIDTH-1:0] o_mem_wmask,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    arb_state_t state;
    arb_owner_t owner;
    logic       ifu_win;
    logic       lsu_win;
`ifdef YSYX_22050710_ARB_RR_EN
    arb_owner_t last_gnt;
`endif

    ysyx_22050710_arb_pick u_pick (
        .ifu_req  (i_ifu_req),
        .lsu_req  (i_lsu_req),
`ifdef YSYX_22050710_ARB_RR_EN
        .last_gnt (last_gnt),
`endif
        .ifu_win  (ifu_win),
        .lsu_win  (lsu_win)
    );

    // Grants are only offered while idle, so a held request yields one transaction.
    assign o_ifu_gnt = (state == IDLE) & ifu_win;
    assign o_lsu_gnt = (state == IDLE) & lsu_win;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            owner        <= OWN_LSU;
            o_mem_req    <= 1'b0;
            o_mem_wen    <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_wmask  <= '0;
            o_ifu_rvalid <= 1'b0;
            o_ifu_rdata  <= '0;
            o_lsu_rvalid <= 1'b0;
            o_lsu_rdata  <= '0;
`ifdef YSYX_22050710_ARB_RR_EN
            last_gnt     <= OWN_LSU;
`endif
        end else begin
            o_ifu_rvalid <= 1'b0;
            o_lsu_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (o_lsu_gnt) begin
                        state       <= REQ;
                        owner       <= OWN_LSU;
                        o_mem_req   <= 1'b1;
                        o_mem_wen   <= i_lsu_wen;
                        o_mem_addr  <= i_lsu_addr;
                        o_mem_wdata <= i_lsu_wdata;
                        o_mem_wmask <= i_lsu_wmask;
`ifdef YSYX_22050710_ARB_RR_EN
                        last_gnt    <= OWN_LSU;
`endif
                    end else if (o_ifu_gnt) begin
                        state       <= REQ;
                        owner       <= OWN_IFU;
                        o_mem_req   <= 1'b1;
                        o_mem_wen   <= 1'b0;
                        o_mem_addr  <= i_ifu_addr;
                        o_mem_wdata <= '0;
                        o_mem_wmask <= '0;
`ifdef YSYX_22050710_ARB_RR_EN
                        last_gnt    <= OWN_IFU;
`endif
                    end
                end
                REQ: begin
                    if (i_mem_gnt) begin
                        o_mem_req <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (i_mem_rvalid) begin
                        state <= IDLE;
                        if (owner == OWN_IFU) begin
                            o_ifu_rvalid <= 1'b1;
                            o_ifu_rdata  <= i_mem_rdata;
                        end else begin
                            o_lsu_rvalid <= 1'b1;
                            o_lsu_rdata  <= i_mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_mem_arbiter.sv
// tb/tb_ysyx_22050710_mem_arbiter.sv - scoreboard bench for the IFU/LSU memory arbiter
// Expectations follow YSYX_22050710_ARB_RR_EN when it is defined.
module tb_ysyx_22050710_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_ifu_req;
    logic [63:0] i_ifu_addr;
    logic        o_ifu_gnt;
    logic        o_ifu_rvalid;
    logic [63:0] o_ifu_rdata;
    logic        i_lsu_req;
    logic        i_lsu_wen;
    logic [63:0] i_lsu_addr;
    logic [63:0] i_lsu_wdata;
    logic [7:0]  i_lsu_wmask;
    logic        o_lsu_gnt;
    logic        o_lsu_rvalid;
    logic [63:0] o_lsu_rdata;
    logic        o_mem_req;
    logic        o_mem_wen;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [63:0] i_mem_rdata;

    ysyx_22050710_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MASK_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ifu_req    (i_ifu_req),
        .i_ifu_addr   (i_ifu_addr),
        .o_ifu_gnt    (o_ifu_gnt),
        .o_ifu_rvalid (o_ifu_rvalid),
        .o_ifu_rdata  (o_ifu_rdata),
        .i_lsu_req    (i_lsu_req),
        .i_lsu_wen    (i_lsu_wen),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wdata  (i_lsu_wdata),
        .i_lsu_wmask  (i_lsu_wmask),
        .o_lsu_gnt    (o_lsu_gnt),
        .o_lsu_rvalid (o_lsu_rvalid),
        .o_lsu_rdata  (o_lsu_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_wen    (o_mem_wen),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wmask  (o_mem_wmask),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    typedef struct packed {
        logic        owner;
        logic        is_wr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   ifu_rv_hist[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ifu_gnt_cyc = 0;
    int   gnt_delay = 0;
    int   rv_delay = 1;
    int   spur_cnt = 0;
    int   spur_done = 0;

    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic        cap_wen;
    logic [7:0]  cap_wmask;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mdata(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0013_0000_0297;
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    task automatic sb_push(input logic own, input logic wr, input logic [63:0] a);
        exp_t e;
        e.owner = own;
        e.is_wr = wr;
        e.data  = wr ? 64'h0 : mdata(a);
        sb.push_back(e);
    endtask

    // Memory model: grant after gnt_delay stall cycles, respond rv_delay cycles after grant.
    initial begin
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (spur_done != spur_cnt) begin
                spur_done++;
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                @(negedge clk);
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = '0;
            end else if (o_mem_req && rst_n) begin
                repeat (gnt_delay) @(negedge clk);
                i_mem_gnt = 1'b1;
                cap_addr  = o_mem_addr;
                cap_wdata = o_mem_wdata;
                cap_wen   = o_mem_wen;
                cap_wmask = o_mem_wmask;
                @(negedge clk);
                i_mem_gnt = 1'b0;
                repeat (rv_delay - 1) @(negedge clk);
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = cap_wen ? 64'h5A5A_5A5A_5A5A_5A5A : mdata(cap_addr);
                @(negedge clk);
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = '0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every requester rvalid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (o_ifu_gnt || o_lsu_gnt)
                check_eq("dual_gnt", 64'(o_ifu_gnt & o_lsu_gnt), 64'h0);
            if (o_ifu_rvalid || o_lsu_rvalid) begin
                if (o_ifu_rvalid) ifu_rv_hist.push_back(cyc);
                if (sb.size() == 0) begin
                    check_eq("unexp_rvalid", 64'({o_ifu_rvalid, o_lsu_rvalid}), 64'h0);
                end else begin
                    check_eq("dual_rvalid", 64'(o_ifu_rvalid & o_lsu_rvalid), 64'h0);
                    e = sb.pop_front();
                    check_eq("rv_owner", 64'(o_lsu_rvalid), 64'(e.owner));
                    if (!e.is_wr)
                        check_eq("rdata", e.owner ? o_lsu_rdata : o_ifu_rdata, e.data);
                end
            end
        end
    end

    task automatic req_ifu(input logic [63:0] a);
        int n;
        n = 0;
        i_ifu_req  = 1'b1;
        i_ifu_addr = a;
        #1;
        while (!o_ifu_gnt && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("ifu_gnt", 64'(o_ifu_gnt), 64'h1);
        ifu_gnt_cyc = cyc;
        @(negedge clk);
        i_ifu_req = 1'b0;
    endtask

    task automatic req_lsu(input logic wr, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        int n;
        n = 0;
        i_lsu_req   = 1'b1;
        i_lsu_wen   = wr;
        i_lsu_addr  = a;
        i_lsu_wdata = d;
        i_lsu_wmask = m;
        #1;
        while (!o_lsu_gnt && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("lsu_gnt", 64'(o_lsu_gnt), 64'h1);
        @(negedge clk);
        i_lsu_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || o_mem_req) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 64'(sb.size()), 64'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_mem_req"}, 64'(o_mem_req), 64'h0);
        check_eq({tag, "_mem_addr"}, o_mem_addr, 64'h0);
        check_eq({tag, "_mem_wen"}, 64'(o_mem_wen), 64'h0);
        check_eq({tag, "_mem_wdata"}, o_mem_wdata, 64'h0);
        check_eq({tag, "_mem_wmask"}, 64'(o_mem_wmask), 64'h0);
        check_eq({tag, "_ifu_rvalid"}, 64'(o_ifu_rvalid), 64'h0);
        check_eq({tag, "_lsu_rvalid"}, 64'(o_lsu_rvalid), 64'h0);
        check_eq({tag, "_ifu_rdata"}, o_ifu_rdata, 64'h0);
        check_eq({tag, "_lsu_rdata"}, o_lsu_rdata, 64'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_idle_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int g2;
        rst_n       = 1'b0;
        i_ifu_req   = 1'b0;
        i_ifu_addr  = '0;
        i_lsu_req   = 1'b0;
        i_lsu_wen   = 1'b0;
        i_lsu_addr  = '0;
        i_lsu_wdata = '0;
        i_lsu_wmask = '0;
        do_reset();

        // 1: IFU fetch, minimum latency
        ifu_rv_hist.delete();
        sb_push(1'b0, 1'b0, 64'h8000_0000);
        req_ifu(64'h8000_0000);
        drain();
        check_eq("t1_addr", cap_addr, 64'h8000_0000);
        check_eq("t1_wen", 64'(cap_wen), 64'h0);
        check_eq("t1_wmask", 64'(cap_wmask), 64'h0);
        check_eq("t1_rdata_hold", o_ifu_rdata, 64'h0000_0013_0000_0297);
        check_eq("t1_latency", 64'((ifu_rv_hist.size() > 0) ? ifu_rv_hist[0] - ifu_gnt_cyc : -1), 64'd3);

        // 2: LSU write
        sb_push(1'b1, 1'b1, 64'h8000_1008);
        req_lsu(1'b1, 64'h8000_1008, 64'hDEAD_BEEF, 8'h0F);
        drain();
        check_eq("t2_wen", 64'(cap_wen), 64'h1);
        check_eq("t2_addr", cap_addr, 64'h8000_1008);
        check_eq("t2_wdata", cap_wdata, 64'hDEAD_BEEF);
        check_eq("t2_wmask", 64'(cap_wmask), 64'h0F);

        // 3: simultaneous requests
        do_reset();
`ifdef YSYX_22050710_ARB_RR_EN
        sb_push(1'b0, 1'b0, 64'h8000_0100);
        sb_push(1'b1, 1'b0, 64'h8000_0200);
`else
        sb_push(1'b1, 1'b0, 64'h8000_0200);
        sb_push(1'b0, 1'b0, 64'h8000_0100);
`endif
        fork
            req_ifu(64'h8000_0100);
            req_lsu(1'b0, 64'h8000_0200, 64'h0, 8'h00);
        join
        drain();

        // 4: memory grant stalled; attributes must stay registered
        gnt_delay = 5;
        sb_push(1'b1, 1'b1, 64'h8000_2000);
        req_lsu(1'b1, 64'h8000_2000, 64'h1122_3344_5566_7788, 8'hF0);
        i_lsu_addr  = '1;
        i_lsu_wdata = '1;
        i_lsu_wmask = '1;
        i_lsu_wen   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            check_eq("t4_req", 64'(o_mem_req), 64'h1);
            check_eq("t4_addr", o_mem_addr, 64'h8000_2000);
            check_eq("t4_wdata", o_mem_wdata, 64'h1122_3344_5566_7788);
            check_eq("t4_wmask", 64'(o_mem_wmask), 64'hF0);
            check_eq("t4_wen", 64'(o_mem_wen), 64'h1);
            @(negedge clk);
        end
        drain();
        gnt_delay = 0;

        // 5: reset while waiting for the response; late response must be dropped
        rv_delay = 3;
        req_ifu(64'h8000_0040);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_req", 64'(o_mem_req), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_idle_outputs("t5");
        rv_delay = 1;

        // 6: spurious response while idle, then back-to-back fetches
        spur_cnt++;
        repeat (4) @(negedge clk);
        check_eq("t6_spur_req", 64'(o_mem_req), 64'h0);
        check_eq("t6_spur_rdata", o_ifu_rdata, 64'h0);
        ifu_rv_hist.delete();
        sb_push(1'b0, 1'b0, 64'h0);
        sb_push(1'b0, 1'b0, 64'h4);
        req_ifu(64'h0);
        req_ifu(64'h4);
        g2 = ifu_gnt_cyc;
        drain();
        check_eq("t6_b2b_gnt", 64'(g2), 64'((ifu_rv_hist.size() > 0) ? ifu_rv_hist[0] : -1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
